aes_ctr_feeder: RTL

Counter-mode front end placed directly upstream of the AES-256 top-level (`top`). It accepts a job (key, IV, block count) over a valid/ready handshake and drives one counter block per cycle onto the core's `STATE`/`KEY` inputs. Because the core pipeline is free-running and carries no qualifier, a matching valid/last tag is delayed by the core's fixed latency, so each output block is flagged when it emerges from `OUT`.

---
 rtl/aes_ctr_pkg.sv | 22 ++
 rtl/aes_vld_pipe.sv | 33 +++
 rtl/aes_ctr_feeder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/aes_ctr_pkg.sv
// Shared types and sizes for the AES-CTR feeder and its tag delay line.
package aes_ctr_pkg;

  localparam int unsigned AES_BLK_W   = 128;
  localparam int unsigned AES_KEY_W   = 256;
  localparam int unsigned NBLK_W      = 32;
  localparam int unsigned DEF_CNT_W   = 32;
  localparam int unsigned DEF_LATENCY = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ctr_state_e;

  // Qualifier carried alongside a block through the free-running core.
  typedef struct packed {
    logic valid;
    logic last;
  } vld_tag_t;

endpackage

// File: rtl/aes_vld_pipe.sv
// LATENCY-deep {valid, last} shift register mirroring the AES core pipeline depth.
module aes_vld_pipe import aes_ctr_pkg::*; #(
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  vld_tag_t tags [LATENCY];

  // Last is masked by valid on entry so it can never appear unqualified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        tags[i] <= '0;
      end
    end else begin
      tags[0].valid <= in_valid;
      tags[0].last  <= in_valid & in_last;
      for (int i = 1; i < LATENCY; i++) begin
        tags[i] <= tags[i-1];
      end
    end
  end

  assign out_valid = tags[LATENCY-1].valid;
  assign out_last  = tags[LATENCY-1].last;

endmodule

// File: rtl/aes_ctr_feeder.sv
// Counter-mode job front end for the AES-256 core; issues one counter block per cycle.
// Optional counter-wrap detection enabled by defining AES_CTR_WRAP_CHECK_EN.
module aes_ctr_feeder import aes_ctr_pkg::*; #(
  parameter int unsigned LATENCY = DEF_LATENCY,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CFG_VALID,
  output logic                 CFG_READY,
  input  logic [AES_KEY_W-1:0] CFG_KEY,
  input  logic [AES_BLK_W-1:0] CFG_IV,
  input  logic [NBLK_W-1:0]    CFG_NBLK,
  input  logic                 HOLD,
  output logic [AES_BLK_W-1:0] STATE,
  output logic [AES_KEY_W-1:0] KEY,
  output logic                 IN_VALID,
  output logic                 KS_VALID,
  output logic                 KS_LAST,
  output logic                 BUSY,
  output logic                 ERR_WRAP
);

  localparam int unsigned NONCE_W = AES_BLK_W - CNT_W;

  ctr_state_e         st;
  logic [NONCE_W-1:0] nonce;
  logic [CNT_W-1:0]   ctr;
  logic [NBLK_W-1:0]  remaining;
  logic               in_last;
  logic               wrap_stop_c;
  logic               issue_last_c;

`ifdef AES_CTR_WRAP_CHECK_EN
  logic err_wrap;
  assign wrap_stop_c = (&ctr) && (remaining > NBLK_W'(1));
  assign ERR_WRAP    = err_wrap;
`else
  assign wrap_stop_c = 1'b0;
  assign ERR_WRAP    = 1'b0;
`endif

  assign issue_last_c = (remaining == NBLK_W'(1)) || wrap_stop_c;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st        <= ST_IDLE;
      CFG_READY <= 1'b1;
      BUSY      <= 1'b0;
      STATE     <= '0;
      KEY       <= '0;
      IN_VALID  <= 1'b0;
      in_last   <= 1'b0;
      nonce     <= '0;
      ctr       <= '0;
      remaining <= '0;
`ifdef AES_CTR_WRAP_CHECK_EN
      err_wrap  <= 1'b0;
`endif
    end else begin
      case (st)
        ST_IDLE: begin
          IN_VALID <= 1'b0;
          in_last  <= 1'b0;
          // A zero-length job is accepted but never leaves IDLE.
          if (CFG_VALID) begin
            KEY       <= CFG_KEY;
            nonce     <= CFG_IV[AES_BLK_W-1:CNT_W];
            ctr       <= CFG_IV[CNT_W-1:0];
            remaining <= CFG_NBLK;
`ifdef AES_CTR_WRAP_CHECK_EN
            err_wrap  <= 1'b0;
`endif
            if (CFG_NBLK != '0) begin
              st        <= ST_RUN;
              CFG_READY <= 1'b0;
              BUSY      <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (HOLD) begin
            IN_VALID <= 1'b0;
            in_last  <= 1'b0;
          end else begin
            STATE     <= {nonce, ctr};
            IN_VALID  <= 1'b1;
            in_last   <= issue_last_c;
            ctr       <= ctr + CNT_W'(1);
            remaining <= remaining - NBLK_W'(1);
`ifdef AES_CTR_WRAP_CHECK_EN
            if (wrap_stop_c) err_wrap <= 1'b1;
`endif
            if (issue_last_c) st <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          IN_VALID <= 1'b0;
          in_last  <= 1'b0;
          if (KS_LAST) begin
            st        <= ST_IDLE;
            CFG_READY <= 1'b1;
            BUSY      <= 1'b0;
          end
        end
        default: begin
          st        <= ST_IDLE;
          CFG_READY <= 1'b1;
          BUSY      <= 1'b0;
          IN_VALID  <= 1'b0;
          in_last   <= 1'b0;
        end
      endcase
    end
  end

  aes_vld_pipe #(.LATENCY(LATENCY)) u_vld_pipe (
    .clk      (CLK),
    .rst_n    (RST_N),
    .in_valid (IN_VALID),
    .in_last  (in_last),
    .out_valid(KS_VALID),
    .out_last (KS_LAST)
  );

endmodule
